// File: rtl/instruction_loader.sv
// Byte-stream program loader: packs bytes little-endian into 32-bit words and writes them to instruction memory.
// Optional `CHECKSUM_EN adds a trailing XOR checksum byte check (CHECK state, checksum_error port).
module instruction_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  im_write_enable,
    output logic [ADDR_WIDTH-1:0] im_write_address,
    output logic [31:0]           im_write_data,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  overflow_error,
`ifdef CHECKSUM_EN
    output logic                  checksum_error,
`endif
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE, RECV, WRITE, DONE, ERROR
`ifdef CHECKSUM_EN
        , CHECK
`endif
    } state_t;

    state_t      state, next_state;
    logic [1:0]  byte_idx;
    logic [31:0] word_reg;
    logic        accept;
    logic        halt;
    logic        last_slot;
    logic        restart;
`ifdef CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept    = byte_valid & byte_ready;
    assign halt      = (word_reg == 32'h0000_0000);
    assign last_slot = &word_count[ADDR_WIDTH-1:0];
    assign restart   = start & ((state == IDLE) | (state == DONE) | (state == ERROR));

    // The write address tracks the word counter; data is the assembly register itself.
    assign im_write_address = word_count[ADDR_WIDTH-1:0];
    assign im_write_data    = word_reg;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            byte_idx       <= 2'd0;
            word_reg       <= 32'h0000_0000;
            word_count     <= '0;
            cpu_reset      <= 1'b1;
            load_done      <= 1'b0;
            overflow_error <= 1'b0;
`ifdef CHECKSUM_EN
            csum           <= 8'h00;
            checksum_error <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            cpu_reset <= (next_state != DONE);
            load_done <= (next_state == DONE);
            if (restart) begin
                byte_idx       <= 2'd0;
                word_count     <= '0;
                overflow_error <= 1'b0;
`ifdef CHECKSUM_EN
                csum           <= 8'h00;
                checksum_error <= 1'b0;
`endif
            end
            if (state == RECV && accept) begin
                word_reg[{byte_idx, 3'b000} +: 8] <= byte_data;
                byte_idx                          <= byte_idx + 2'd1;
`ifdef CHECKSUM_EN
                csum                              <= csum ^ byte_data;
`endif
            end
            if (state == WRITE) begin
                word_count <= word_count + (ADDR_WIDTH+1)'(1);
                if (next_state == ERROR)
                    overflow_error <= 1'b1;
            end
`ifdef CHECKSUM_EN
            if (state == CHECK && byte_valid && byte_data != csum)
                checksum_error <= 1'b1;
`endif
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: if (start) next_state = RECV;
            RECV:  if (accept && byte_idx == 2'd3) next_state = WRITE;
            WRITE: begin
                if (halt)
`ifdef CHECKSUM_EN
                    next_state = CHECK;
`else
                    next_state = DONE;
`endif
                else if (last_slot)
                    next_state = ERROR;
                else
                    next_state = RECV;
            end
`ifdef CHECKSUM_EN
            CHECK: if (byte_valid) next_state = (byte_data == csum) ? DONE : ERROR;
`endif
            default: next_state = IDLE;
        endcase
    end

    // Output decode of the state register
    always_comb begin
        byte_ready      = (state == RECV);
`ifdef CHECKSUM_EN
        byte_ready      = (state == RECV) | (state == CHECK);
`endif
        im_write_enable = (state == WRITE);
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader (ADDR_WIDTH=2 so overflow is reachable quickly).
module tb_instruction_loader;
    localparam int AW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          im_write_enable;
    logic [AW-1:0] im_write_address;
    logic [31:0]   im_write_data;
    logic          cpu_reset;
    logic          load_done;
    logic          overflow_error;
    logic [AW:0]   word_count;
`ifdef CHECKSUM_EN
    logic          checksum_error;
`endif

    int checks = 0;
    int errors = 0;
    int strobe_n = 0;
    logic [AW-1:0] wa [8];
    logic [31:0]   wd [8];
    logic          wbr [8];
    logic          wcr [8];

    instruction_loader #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .im_write_enable(im_write_enable), .im_write_address(im_write_address),
        .im_write_data(im_write_data), .cpu_reset(cpu_reset), .load_done(load_done),
        .overflow_error(overflow_error),
`ifdef CHECKSUM_EN
        .checksum_error(checksum_error),
`endif
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    // Strobe log, sampled mid-cycle
    always @(negedge clock) begin
        if (im_write_enable) begin
            if (strobe_n < 8) begin
                wa[strobe_n]  = im_write_address;
                wd[strobe_n]  = im_write_data;
                wbr[strobe_n] = byte_ready;
                wcr[strobe_n] = cpu_reset;
            end
            strobe_n = strobe_n + 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 20) begin
            tick();
            n++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: byte_ready=%0b required 1", byte_ready);
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            send_byte(b);
            if (gap) tick();
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL rst_byte_ready: got %b want 0", byte_ready); end
        checks++; if (im_write_enable !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", im_write_enable); end
        checks++; if (im_write_address !== 2'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", im_write_address); end
        checks++; if (im_write_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", im_write_data); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done: got %b want 0", load_done); end
        checks++; if (overflow_error !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow_error); end
        checks++; if (word_count !== 3'd0) begin errors++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
        #2 reset = 1'b1;
        tick();
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL idle_no_ready: got %b want 0", byte_ready); end
    endtask

    task automatic test_basic();
        strobe_n = 0;
        pulse_start();
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", byte_ready); end
        send_word(32'h0010_0013, 1'b0);
        send_word(32'h0000_0000, 1'b0);
        checks++; if (im_write_enable !== 1'b1) begin errors++; $display("FAIL basic_we2: got %b want 1", im_write_enable); end
        checks++; if (im_write_address !== 2'd1) begin errors++; $display("FAIL basic_addr2: got %h want 1", im_write_address); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL basic_cpurst_at_we: got %b want 1", cpu_reset); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_at_we: got %b want 0", byte_ready); end
        tick();
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL basic_cpurst_after: got %b want 0", cpu_reset); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", load_done); end
        checks++; if (im_write_enable !== 1'b0) begin errors++; $display("FAIL basic_we_after: got %b want 0", im_write_enable); end
        checks++; if (word_count !== 3'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", word_count); end
        checks++; if (strobe_n !== 2) begin errors++; $display("FAIL basic_strobes: got %0d want 2", strobe_n); end
        checks++; if (wa[0] !== 2'd0 || wd[0] !== 32'h0010_0013) begin errors++; $display("FAIL basic_w0: got %h@%0d want 00100013@0", wd[0], wa[0]); end
        checks++; if (wa[1] !== 2'd1 || wd[1] !== 32'h0) begin errors++; $display("FAIL basic_w1: got %h@%0d want 00000000@1", wd[1], wa[1]); end
        repeat (3) tick();
        checks++; if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL basic_hold: done=%b cpu_reset=%b want 1/0", load_done, cpu_reset); end
    endtask

    task automatic test_reload_gaps();
        logic [31:0] exp [4];
        exp[0] = 32'h0403_0201; exp[1] = 32'h8899_aabb; exp[2] = 32'hdead_beef; exp[3] = 32'h0;
        strobe_n = 0;
        pulse_start();
        checks++; if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL reload_flags: cpu_reset=%b done=%b want 1/0", cpu_reset, load_done); end
        checks++; if (word_count !== 3'd0) begin errors++; $display("FAIL reload_count: got %0d want 0", word_count); end
        for (int i = 0; i < 4; i++) send_word(exp[i], 1'b1);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL gaps_done: got %b want 1", load_done); end
        checks++; if (word_count !== 3'd4) begin errors++; $display("FAIL gaps_count: got %0d want 4", word_count); end
        checks++; if (strobe_n !== 4) begin errors++; $display("FAIL gaps_strobes: got %0d want 4", strobe_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa[i] !== AW'(i) || wd[i] !== exp[i] || wbr[i] !== 1'b0 || wcr[i] !== 1'b1) begin
                errors++;
                $display("FAIL gaps_w%0d: got %h@%0d ready=%b cpu_reset=%b want %h@%0d ready=0 cpu_reset=1",
                         i, wd[i], wa[i], wbr[i], wcr[i], exp[i], i);
            end
        end
    endtask

    task automatic test_overflow();
        strobe_n = 0;
        pulse_start();
        send_word(32'h1111_1111, 1'b0);
        send_word(32'h2222_2222, 1'b0);
        send_word(32'h3333_3333, 1'b0);
        send_word(32'h4444_4444, 1'b0);
        tick();
        checks++; if (overflow_error !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow_error); end
        checks++; if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL ovf_cpu: cpu_reset=%b done=%b want 1/0", cpu_reset, load_done); end
        checks++; if (word_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", word_count); end
        checks++; if (strobe_n !== 4) begin errors++; $display("FAIL ovf_strobes: got %0d want 4", strobe_n); end
        checks++; if (wa[3] !== 2'd3 || wd[3] !== 32'h4444_4444) begin errors++; $display("FAIL ovf_w3: got %h@%0d want 44444444@3", wd[3], wa[3]); end
        repeat (3) tick();
        checks++; if (overflow_error !== 1'b1 || byte_ready !== 1'b0) begin errors++; $display("FAIL ovf_hold: ovf=%b ready=%b want 1/0", overflow_error, byte_ready); end
        strobe_n = 0;
        pulse_start();
        checks++; if (overflow_error !== 1'b0 || word_count !== 3'd0) begin errors++; $display("FAIL ovf_restart: ovf=%b count=%0d want 0/0", overflow_error, word_count); end
        send_word(32'h0, 1'b0);
        tick();
        checks++; if (strobe_n !== 1 || wa[0] !== 2'd0 || load_done !== 1'b1) begin errors++; $display("FAIL ovf_reload: strobes=%0d addr=%0d done=%b want 1/0/1", strobe_n, wa[0], load_done); end
    endtask

    task automatic test_reset_mid();
        strobe_n = 0;
        pulse_start();
        send_word(32'hcafe_f00d, 1'b0);
        send_byte(8'h01);
        send_byte(8'h02);
        #2 reset = 1'b0;
        #1;
        checks++; if (byte_ready !== 1'b0 || im_write_enable !== 1'b0) begin errors++; $display("FAIL mid_rst_hs: ready=%b we=%b want 0/0", byte_ready, im_write_enable); end
        checks++; if (im_write_address !== 2'd0 || im_write_data !== 32'h0) begin errors++; $display("FAIL mid_rst_bus: %h@%0d want 0@0", im_write_data, im_write_address); end
        checks++; if (cpu_reset !== 1'b1 || load_done !== 1'b0 || overflow_error !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: cpu_reset=%b done=%b ovf=%b want 1/0/0", cpu_reset, load_done, overflow_error); end
        checks++; if (word_count !== 3'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", word_count); end
        tick();
        checks++; if (strobe_n !== 1) begin errors++; $display("FAIL mid_rst_strobes: got %0d want 1", strobe_n); end
        #2 reset = 1'b1;
        tick();
        strobe_n = 0;
        pulse_start();
        send_word(32'h0010_0013, 1'b0);
        send_word(32'h0, 1'b0);
        tick();
        checks++; if (strobe_n !== 2) begin errors++; $display("FAIL mid_reload_strobes: got %0d want 2", strobe_n); end
        checks++; if (wa[0] !== 2'd0 || wd[0] !== 32'h0010_0013) begin errors++; $display("FAIL mid_reload_w0: got %h@%0d want 00100013@0", wd[0], wa[0]); end
        checks++; if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL mid_reload_done: done=%b cpu_reset=%b want 1/0", load_done, cpu_reset); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload_gaps();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Byte-stream program loader: the write side of the processor's instruction memory. It accepts bytes over a valid/ready handshake, packs them little-endian into 32-bit words, and writes them to consecutive instruction-memory word addresses. It holds the processor in reset while loading. It releases the processor once the 32'h00000000 halt word has been written.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  single-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERROR.
byte_valid  input  1  byte_data is valid.
byte_data  input  8  program byte.
byte_ready  output  1  loader accepts a byte this cycle.
im_write_enable  output  1  one-cycle instruction-memory write strobe.
im_write_address  output  ADDR_WIDTH  word address of the write.
im_write_data  output  32  word to write.
cpu_reset  output  1  active-high reset to single_cycle_processor.
load_done  output  1  program loaded, processor running.
overflow_error  output  1  memory filled without a halt word.
word_count  output  ADDR_WIDTH+1  number of words written in the current load.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - byte_ready=0, im_write_enable=0, im_write_address=0, im_write_data=0.
  - cpu_reset=1, load_done=0, overflow_error=0, word_count=0, byte index=0.
- All outputs are registered. byte_ready is a decode of the state register only.
- FSM states: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE:
  - cpu_reset=1, byte_ready=0.
  - start -> RECV. On entry: word_count=0, byte index=0, overflow_error=0, load_done=0.
- RECV:
  - byte_ready=1. A byte transfers on byte_valid & byte_ready.
  - Byte n (n=0..3) lands in bits [8n+7:8n] of the assembly register.
  - The transfer of byte 3 moves to WRITE and clears the byte index.
  - byte_valid=0 holds state; there is no timeout.
- WRITE (exactly one cycle):
  - byte_ready=0, im_write_enable=1.
  - im_write_address = word_count[ADDR_WIDTH-1:0]; im_write_data = assembled word.
  - word_count increments.
  - Word == 32'h00000000 -> DONE. The halt word itself is written.
  - Otherwise, if word_count was 2^ADDR_WIDTH-1 before the increment -> ERROR.
  - Otherwise -> RECV.
- Throughput: at most 4 bytes per 5 cycles. The write strobe occurs on the cycle after the 4th byte is accepted.
- DONE:
  - cpu_reset=0, load_done=1, byte_ready=0. Held indefinitely.
  - start -> RECV, with cpu_reset=1 and load_done=0 in the same transition.
- ERROR:
  - cpu_reset=1, overflow_error=1, byte_ready=0.
  - start -> RECV, with overflow_error cleared.
- start is ignored in RECV and WRITE. A partial word is never discarded except by reset.
- Reset mid-load: returns to IDLE with the partial word lost. No write strobe is issued on the reset edge.
- cpu_reset is never 0 while im_write_enable is 1.

Optional Feature:
CHECKSUM_EN
- Defined:
  - After the halt word is written, the loader enters CHECK instead of DONE, with byte_ready=1.
  - It accepts one extra byte and compares it against the XOR of all program bytes, halt word included.
  - Match -> DONE.
  - Mismatch -> ERROR, with output port checksum_error=1 (1 bit, reset 0, cleared by start).
- Undefined: there is no CHECK state and no checksum_error port. The halt word goes straight to DONE.

Test Plan:
- Basic load: send bytes 13,00,10,00 then 00,00,00,00 -> two strobes.
  - Address 0 receives 32'h00100013; address 1 receives 32'h00000000.
  - word_count=2, load_done=1, cpu_reset falls one cycle after the second strobe.
- Backpressure and gaps: byte_valid toggles every other cycle.
  - Words are assembled identically; only 4 strobes are produced for 16 bytes.
  - byte_ready=0 on every WRITE cycle.
- Overflow: ADDR_WIDTH=2, send 4 non-zero words.
  - Strobes go to addresses 0..3, then overflow_error=1 and cpu_reset stays 1.
  - start then restarts the load at address 0.
- Reset mid-load: assert reset=0 after byte 2 of word 1.
  - All outputs return to reset values asynchronously.
  - A new start plus a full program loads correctly from address 0.
- Reload from DONE: pulse start in DONE.
  - cpu_reset=1 and load_done=0 on the next cycle.
  - The second program overwrites from address 0.
- CHECKSUM_EN: program 01,00,00,00,00,00,00,00.
  - Checksum byte 01 -> DONE.
  - Checksum byte 02 -> ERROR with checksum_error=1.
